input_debouncer: RTL and testbench

Input-conditioning stage that sits directly upstream of the flip-flop stage and drives its `d_i`. It takes a raw, asynchronous, possibly bouncing 1-bit signal and passes it through a synchroniser chain into the `clk` domain. It then filters the result with a stability counter and publishes a clean level plus single-cycle rise/fall strobes. Every output is registered, so downstream flops sample a glitch-free, domain-local signal.

---
 rtl/input_debouncer_if.sv | 28 ++
 rtl/input_debouncer.sv | 75 +++++++
 tb/tb_input_debouncer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// Signal bundle between the debouncer and its user: raw input and clear in,
// debounced level, edge strobes and busy flag out.
interface input_debouncer_if;
    logic clear_i;
    logic raw_i;
    logic level_o;
    logic rise_o;
    logic fall_o;
    logic busy_o;

    modport master (
        output clear_i,
        output raw_i,
        input  level_o,
        input  rise_o,
        input  fall_o,
        input  busy_o
    );

    modport slave (
        input  clear_i,
        input  raw_i,
        output level_o,
        output rise_o,
        output fall_o,
        output busy_o
    );
endinterface

// File: rtl/input_debouncer.sv
// Synchronises a raw asynchronous input into clk and filters it with a
// stability counter, publishing a registered level plus rise/fall strobes.
module input_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic               clk,
    input logic               reset_async,
    input_debouncer_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    logic                   w_sync_q;
    logic [CW-1:0]          w_cnt_nxt;
    logic                   w_level_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;

    // Plain shift chain; clear_i deliberately does not touch it.
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.raw_i};
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (bus.clear_i) begin
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
        end else if (w_sync_q == r_level) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_level_nxt = w_sync_q;
            w_cnt_nxt   = '0;
            w_rise_nxt  = w_sync_q;
            w_fall_nxt  = ~w_sync_q;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign bus.level_o = r_level;
    assign bus.rise_o  = r_rise;
    assign bus.fall_o  = r_fall;
    assign bus.busy_o  = (r_cnt != '0);
endmodule

// File: tb/tb_input_debouncer.sv
// Randomised and directed bench for input_debouncer with a queue-based
// scoreboard fed by a run-length reference model.
module tb_input_debouncer;
    localparam int unsigned S = 2;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic reset_async = 1'b1;

    input_debouncer_if dbg_if ();

    input_debouncer #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk         (clk),
        .reset_async (reset_async),
        .bus         (dbg_if.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Expected {level, rise, fall, busy} after each clock edge.
    logic [3:0] exp_q[$];

    // Reference model: raw delayed S edges, then a run of D consecutive
    // disagreeing samples flips the level.
    logic raw_hist[$];
    logic m_level = 1'b0;
    int unsigned m_run = 0;

    task automatic model_reset();
        raw_hist.delete();
        for (int i = 0; i < int'(S); i++) raw_hist.push_back(1'b0);
        m_level = 1'b0;
        m_run   = 0;
        exp_q.delete();
    endtask

    initial model_reset();

    always @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            model_reset();
        end else begin
            logic s;
            logic rise, fall;
            s = raw_hist.pop_front();
            raw_hist.push_back(dbg_if.raw_i);
            rise = 1'b0;
            fall = 1'b0;
            if (dbg_if.clear_i) begin
                m_level = 1'b0;
                m_run   = 0;
            end else if (s == m_level) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == D) begin
                    m_level = s;
                    m_run   = 0;
                    rise    = s;
                    fall    = ~s;
                end
            end
            exp_q.push_back({m_level, rise, fall, (m_run != 0)});
        end
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got lvl/rise/fall/busy=%b required=%b at %0t", name, got, exp, $time);
    endtask

    // Monitor: compare outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] got;
        got = {dbg_if.level_o, dbg_if.rise_o, dbg_if.fall_o, dbg_if.busy_o};
        if (reset_async) check("in_reset", got, 4'b0000);
        else if (exp_q.size() > 0) check("scoreboard", got, exp_q.pop_front());
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int unsigned k;
        dbg_if.raw_i   = 1'b1;
        dbg_if.clear_i = 1'b0;

        // Reset held with raw high; monitor expects all-zero outputs.
        cycles(3);
        reset_async = 1'b0;

        // Latency from reset release with stable raw=1: rise after edge 6.
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (dbg_if.rise_o && k == 0) k = i;
        end
        n_checks++;
        if (k == S + D) n_pass++;
        else $display("FAIL rise_latency: got edge %0d required edge %0d", k, S + D);

        // Clean fall.
        dbg_if.raw_i = 1'b0;
        cycles(12);

        // Glitches of D-1 and D cycles.
        dbg_if.raw_i = 1'b1; cycles(D - 1); dbg_if.raw_i = 1'b0; cycles(12);
        dbg_if.raw_i = 1'b1; cycles(D);     dbg_if.raw_i = 1'b0; cycles(12);

        // Bounce every 2 cycles, then settle high.
        for (int i = 0; i < 10; i++) begin
            dbg_if.raw_i = ~dbg_if.raw_i;
            cycles(2);
        end
        dbg_if.raw_i = 1'b1;
        cycles(12);

        // Clear on the edge where the count would complete.
        dbg_if.raw_i = 1'b0; cycles(12);
        dbg_if.raw_i = 1'b1; cycles(5);
        dbg_if.clear_i = 1'b1; cycles(1);
        dbg_if.clear_i = 1'b0; cycles(12);

        // Asynchronous reset mid-count; outputs must drop before the next edge.
        dbg_if.raw_i = 1'b0; cycles(12);
        dbg_if.raw_i = 1'b1; cycles(4);
        #2 reset_async = 1'b1;
        #1 check("async_reset_now", {dbg_if.level_o, dbg_if.rise_o, dbg_if.fall_o, dbg_if.busy_o}, 4'b0000);
        cycles(2);
        reset_async = 1'b0;
        cycles(12);

        // Random runs with occasional clears.
        for (int i = 0; i < 60; i++) begin
            dbg_if.raw_i = 1'($urandom_range(0, 1));
            for (int j = 0; j < int'($urandom_range(1, 7)); j++) begin
                dbg_if.clear_i = ($urandom_range(0, 39) == 0);
                cycles(1);
            end
        end
        dbg_if.clear_i = 1'b0;
        cycles(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
